// File: rtl/md_sequencer_pkg.sv
// Shared MD opcode and state encodings for the multiply/divide sequencer.
package md_sequencer_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  localparam int MD_MULT_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF  = 10;
  localparam int MD_CNT_W_DEF    = 4;

  // Ops that occupy the multi-cycle window.
  function automatic logic md_is_arith(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Signed division goes through
// magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        dz
);

  md_op_t             op_t;
  logic signed [63:0] a_sx, b_sx, prod_s;
  logic [63:0]        prod_u;
  logic               b_zero, a_neg, b_neg;
  logic [31:0]        b_safe, a_mag, b_mag, b_mag_safe;
  logic [31:0]        uq, ur, sq_mag, sr_mag, sq, sr;

  assign op_t   = md_op_t'(op);
  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // A zero divisor is replaced by 1 so the dividers never see zero; the
  // result is discarded by the sequencer anyway when dz is set.
  assign b_zero     = (b == 32'd0);
  assign b_safe     = b_zero ? 32'd1 : b;
  assign a_neg      = a[31];
  assign b_neg      = b[31];
  assign a_mag      = a_neg ? (32'd0 - a) : a;
  assign b_mag      = b_neg ? (32'd0 - b) : b;
  assign b_mag_safe = b_zero ? 32'd1 : b_mag;

  assign uq     = a / b_safe;
  assign ur     = a % b_safe;
  assign sq_mag = a_mag / b_mag_safe;
  assign sr_mag = a_mag % b_mag_safe;
  assign sq     = (a_neg ^ b_neg) ? (32'd0 - sq_mag) : sq_mag;
  assign sr     = a_neg ? (32'd0 - sr_mag) : sr_mag;

  // Select hi/lo results for the requested operation.
  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    dz     = 1'b0;
    case (op_t)
      MD_MULT: begin
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
      end
      MD_MULTU: begin
        hi_res = prod_u[63:32];
        lo_res = prod_u[31:0];
      end
      MD_DIV: begin
        hi_res = sr;
        lo_res = sq;
        dz     = b_zero;
      end
      MD_DIVU: begin
        hi_res = ur;
        lo_res = uq;
        dz     = b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, holds them through a fixed-latency
// busy window, then commits the result latched at start.
//
// state   | meaning
// ST_IDLE | accepting MD ops; MTHI/MTLO write immediately
// ST_BUSY | arithmetic op in flight; cnt counts down to the commit edge
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT_DEF,
  parameter int DIV_LAT  = MD_DIV_LAT_DEF,
  parameter int CNT_W    = MD_CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_use_D,
  output logic        busy,
  output logic        start,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_op_t           op_e;
  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q, lo_q, hi_pend, lo_pend;
  logic             dz_pend;
  logic [31:0]      hi_res, lo_res;
  logic             dz_res;
  logic             commit;
  logic             idle_mthi, idle_mtlo;

  assign op_e = md_op_t'(md_op_E);

  md_arith u_arith (
    .op     (md_op_E),
    .a      (rs_E),
    .b      (rt_E),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .dz     (dz_res)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, start and commit strobes.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (md_is_arith(op_e)) begin
          start   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latency down-counter: loaded at start, terminal count 1 marks commit.
  always_ff @(posedge clk) begin
    if (reset)                cnt_q <= '0;
    else if (start)           cnt_q <= md_is_div(op_e) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    else if (state_q == ST_BUSY) cnt_q <= cnt_q - CNT_W'(1);
  end

  // Capture the result at start; it stays hidden until commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_pend <= 32'd0;
      lo_pend <= 32'd0;
      dz_pend <= 1'b0;
    end else if (start) begin
      hi_pend <= hi_res;
      lo_pend <= lo_res;
      dz_pend <= dz_res;
    end
  end

  assign idle_mthi = (state_q == ST_IDLE) && (op_e == MD_MTHI);
  assign idle_mtlo = (state_q == ST_IDLE) && (op_e == MD_MTLO);

  // HI/LO: commit of a non-divide-by-zero result, or a direct move while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      if (commit && !dz_pend) hi_q <= hi_pend;
      else if (idle_mthi)     hi_q <= rs_E;
      if (commit && !dz_pend) lo_q <= lo_pend;
      else if (idle_mtlo)     lo_q <= rs_E;
    end
  end

  assign busy     = (state_q == ST_BUSY);
  assign stall_md = md_use_D & (busy | start);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with a cycle-level reference model.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op_E;
  logic [31:0] rs_E, rt_E;
  logic        md_use_D;
  logic        busy, start, stall_md;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op_E  (md_op_E),
    .rs_E     (rs_E),
    .rt_E     (rt_E),
    .md_use_D (md_use_D),
    .busy     (busy),
    .start    (start),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on 64-bit integers.
  function automatic void model_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l, output bit dz);
    longint sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    h = 32'd0; l = 32'd0; dz = 1'b0;
    case (op)
      3'd1: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      3'd2: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      3'd3: if (b == 32'd0) dz = 1'b1;
            else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
      3'd4: if (b == 32'd0) dz = 1'b1;
            else begin uq = ua / ub; ur = ua % ub; l = uq[31:0]; h = ur[31:0]; end
      default: ;
    endcase
  endfunction

  // Model: remaining busy cycles plus pending result.
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_ph = 32'd0, m_pl = 32'd0;
  bit          m_pdz = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin : model_upd
    logic [31:0] ch, cl;
    bit          cdz;
    if (reset) begin
      m_valid <= 1'b1;
      m_left  <= 0;
      m_hi    <= 32'd0;
      m_lo    <= 32'd0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && !m_pdz) begin
        m_hi <= m_ph;
        m_lo <= m_pl;
      end
    end else begin
      case (md_op_E)
        3'd1, 3'd2, 3'd3, 3'd4: begin
          model_calc(md_op_E, rs_E, rt_E, ch, cl, cdz);
          m_ph   <= ch;
          m_pl   <= cl;
          m_pdz  <= cdz;
          m_left <= (md_op_E >= 3'd3) ? 10 : 5;
        end
        3'd5: m_hi <= rs_E;
        3'd6: m_lo <= rs_E;
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    logic e_busy, e_start, e_stall;
    if (m_valid) begin
      e_busy  = (m_left > 0);
      e_start = (m_left == 0) && (md_op_E >= 3'd1) && (md_op_E <= 3'd4);
      e_stall = md_use_D & (e_busy | e_start);
      chk("cmp.busy",  {31'd0, busy},     {31'd0, e_busy});
      chk("cmp.start", {31'd0, start},    {31'd0, e_start});
      chk("cmp.stall", {31'd0, stall_md}, {31'd0, e_stall});
      chk("cmp.hi", hi, m_hi);
      chk("cmp.lo", lo, m_lo);
    end
  end

  // Ops must never be issued while an op is in flight.
  always @(posedge clk) begin
    if (m_valid && !reset && busy === 1'b1 && md_op_E >= 3'd1 && md_op_E <= 3'd6) begin
      failures++;
      $display("FAIL protocol op=%0d issued while busy t=%0t", md_op_E, $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input int exp_busy, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int nb;
    md_op_E = op; rs_E = a; rt_E = b; md_use_D = use_d;
    #1;
    chk({name, ".start"}, {31'd0, start}, 32'd1);
    chk({name, ".stall_start"}, {31'd0, stall_md}, {31'd0, use_d});
    step();
    md_op_E = 3'd0;
    nb = 0;
    while (busy === 1'b1 && nb < 30) begin
      #1;
      chk({name, ".stall_busy"}, {31'd0, stall_md}, {31'd0, use_d});
      nb++;
      step();
    end
    #1;
    chk({name, ".busy_len"}, 32'(nb), 32'(exp_busy));
    chk({name, ".stall_done"}, {31'd0, stall_md}, 32'd0);
    chk({name, ".hi"}, hi, exp_hi);
    chk({name, ".lo"}, lo, exp_lo);
    md_use_D = 1'b0;
  endtask

  task automatic move(input string name, input logic [2:0] op, input logic [31:0] v,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    md_op_E = op; rs_E = v; rt_E = 32'd0;
    #1;
    chk({name, ".start"}, {31'd0, start}, 32'd0);
    step();
    md_op_E = 3'd0;
    #1;
    chk({name, ".busy"}, {31'd0, busy}, 32'd0);
    chk({name, ".hi"}, hi, exp_hi);
    chk({name, ".lo"}, lo, exp_lo);
  endtask

  initial begin
    reset = 1'b1; md_op_E = 3'd0; rs_E = 32'd0; rt_E = 32'd0; md_use_D = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.hi", hi, 32'd0);
    chk("reset.lo", lo, 32'd0);

    run_op("mult_neg",  3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 5,  32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu",     3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 5,  32'h00000001, 32'hFFFFFFFE);
    run_op("div_neg",   3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf",   3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'h00000000, 32'h80000000);
    run_op("div_negb",  3'd3, 32'd7, 32'hFFFFFFFE, 1'b0, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu",      3'd4, 32'd100, 32'd7, 1'b0, 10, 32'd2, 32'd14);

    move("mthi", 3'd5, 32'h1234, 32'h1234, 32'd14);
    move("mtlo", 3'd6, 32'h5678, 32'h1234, 32'h5678);
    run_op("divu_dz",   3'd4, 32'hDEAD, 32'd0, 1'b0, 10, 32'h1234, 32'h5678);
    run_op("div_dz",    3'd3, 32'hFFFF0000, 32'd0, 1'b0, 10, 32'h1234, 32'h5678);

    run_op("stall_on",  3'd1, 32'h00010000, 32'h00010000, 1'b1, 5, 32'h00000001, 32'h00000000);
    run_op("stall_off", 3'd1, 32'd5, 32'hFFFFFFFF, 1'b0, 5, 32'hFFFFFFFF, 32'hFFFFFFFB);

    // Reset arriving in the third busy cycle of a divide.
    move("mthi2", 3'd5, 32'hAAAA, 32'hAAAA, 32'hFFFFFFFB);
    md_op_E = 3'd3; rs_E = 32'd100; rt_E = 32'd7;
    step();
    md_op_E = 3'd0;
    step(); step();
    chk("rst_mid.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid.busy", {31'd0, busy}, 32'd0);
    chk("rst_mid.hi", hi, 32'd0);
    chk("rst_mid.lo", lo, 32'd0);
    run_op("mult_3x4", 3'd1, 32'd3, 32'd4, 1'b0, 5, 32'd0, 32'd12);

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
